// File: rtl/vigna_pkg.sv
// Shared constants and types for the vigna instruction fetch path.
package vigna_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Prefetch request tracker: no request, request whose data is kept,
    // request whose data is thrown away once it returns.
    typedef enum logic [1:0] {
        PF_IDLE,
        PF_FETCH,
        PF_DISCARD
    } pf_state_e;

endpackage

// File: rtl/vigna_sync_fifo.sv
// Single-clock FIFO with combinational head read, synchronous clear and
// occupancy count. Pointers wrap naturally on log2(DEPTH) bits.
module vigna_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pop needs data present; push into a full FIFO is allowed only
    // when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
    end

    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear overrides push/pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vigna_ifetch_prefetch.sv
// Sequential instruction prefetch buffer between the vigna core fetch port
// and instruction memory. Streams ahead at +4 while the core keeps hitting,
// and flushes/redirects when the core leaves the stream or on flush.
module vigna_ifetch_prefetch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            c_valid,
    input  logic [XLEN-1:0] c_addr,
    output logic            c_ready,
    output logic [XLEN-1:0] c_rdata,
    output logic            m_valid,
    output logic [XLEN-1:0] m_addr,
    input  logic            m_ready,
    input  logic [XLEN-1:0] m_rdata
);
    import vigna_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    pf_state_e       state;
    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] fetch_addr;
    logic            stream_valid;

    logic [XLEN-1:0] fifo_rdata;
    logic [CW-1:0]   fifo_count;

    logic            eval;
    logic [XLEN-1:0] c_word;
    logic            addr_match;
    logic            do_hit;
    logic            do_miss;
    logic            fifo_clear;
    logic            fifo_push;
    logic [CW-1:0]   count_nxt;
    logic            sv_nxt;
    logic [XLEN-1:0] fetch_nxt;
    logic            req_held;
    logic            issue;

    vigna_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (do_hit),
        .clear  (fifo_clear),
        .wdata  (m_rdata),
        .rdata  (fifo_rdata),
        .count  (fifo_count)
    );

    // Request classification and post-edge view of stream/FIFO, used so
    // a new memory request can be issued on the same edge that frees the
    // tracker (back-to-back, or straight after a redirect).
    always_comb begin
        eval       = c_valid && !c_ready;
        c_word     = c_addr & ~XLEN'(3);
        addr_match = stream_valid && (c_word == head_addr);
        do_hit     = !flush && eval && addr_match && (fifo_count != '0);
        do_miss    = !flush && eval && !addr_match;
        fifo_clear = flush || do_miss;
        fifo_push  = (state == PF_FETCH) && m_ready && !fifo_clear;

        count_nxt = fifo_count + CW'(fifo_push) - CW'(do_hit);
        if (fifo_clear) count_nxt = '0;

        sv_nxt = stream_valid;
        if (do_miss) sv_nxt = 1'b1;
        if (flush)   sv_nxt = 1'b0;

        fetch_nxt = fetch_addr;
        if (fifo_push) fetch_nxt = fetch_addr + STEP;
        if (do_miss)   fetch_nxt = c_word;

        req_held = (state != PF_IDLE) && !m_ready;
        issue    = !req_held && sv_nxt && (count_nxt < CW'(DEPTH));
    end

    // Stream pointers, core response and memory request FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= PF_IDLE;
            head_addr    <= '0;
            fetch_addr   <= '0;
            stream_valid <= 1'b0;
            c_ready      <= 1'b0;
            c_rdata      <= '0;
            m_valid      <= 1'b0;
            m_addr       <= '0;
        end else begin
            c_ready <= do_hit;
            if (do_hit) begin
                c_rdata   <= fifo_rdata;
                head_addr <= head_addr + STEP;
            end
            if (do_miss) head_addr <= c_word;
            stream_valid <= sv_nxt;
            fetch_addr   <= fetch_nxt;

            if (req_held) begin
                // Outstanding request must complete unchanged; its data is
                // only useful if the stream survived.
                if ((state == PF_FETCH) && fifo_clear) state <= PF_DISCARD;
            end else if (issue) begin
                state   <= PF_FETCH;
                m_valid <= 1'b1;
                m_addr  <= fetch_nxt;
            end else begin
                state   <= PF_IDLE;
                m_valid <= 1'b0;
            end
        end
    end

endmodule
